// File: rtl/gpu_pixel_writer_pkg.sv
// Shared framebuffer geometry, pixel entry type and address helper for the
// pixel writer and its FIFO.

`ifndef GPU_DEFINITIONS_VH
`define GPU_DEFINITIONS_VH
`define WIDTH        640
`define HEIGHT       480
`define WIDTH_BITS   10
`define HEIGHT_BITS  9
`define CHANNEL_BITS 8
`define PIXEL_BITS   24
`define ADDR_BITS    19
`endif

package gpu_pixel_writer_pkg;

  localparam int X_W     = `WIDTH_BITS;
  localparam int Y_W     = `HEIGHT_BITS;
  localparam int CH_W    = `CHANNEL_BITS;
  localparam int ADDR_W  = `ADDR_BITS;
  localparam int PIXEL_W = `PIXEL_BITS;

  // Coordinates at or beyond these limits are off-screen (includes the sentinel).
  localparam logic [X_W-1:0] X_LIMIT = X_W'(`WIDTH);
  localparam logic [Y_W-1:0] Y_LIMIT = Y_W'(`HEIGHT);

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [PIXEL_W-1:0] data;
  } pixel_t;

  // Linear address Y*WIDTH+X, every operand widened to the full address width.
  function automatic logic [ADDR_W-1:0] linear_addr(input logic [X_W-1:0] x,
                                                    input logic [Y_W-1:0] y);
    return ADDR_W'(y) * ADDR_W'(`WIDTH) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/gpu_pixel_fifo.sv
// Show-ahead synchronous FIFO: one write port, one read port, occupancy count.
// A push while full is accepted only if a pop happens on the same edge.

module gpu_pixel_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       pop,
  output logic [DATA_W-1:0]          rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage array written on accepted pushes.
  // NOTE: the data array has no reset; only pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gpu_pixel_writer.sv
// Turns the per-cycle coordinate stream of the circle filler into ordered
// framebuffer writes: validity and duplicate filter, address/colour stage,
// pixel FIFO, and a request/acknowledge output stage.

module gpu_pixel_writer
  import gpu_pixel_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [X_W-1:0]                  X_i,
  input  logic [Y_W-1:0]                  Y_i,
  input  logic [CH_W-1:0]                 r_i,
  input  logic [CH_W-1:0]                 g_i,
  input  logic [CH_W-1:0]                 b_i,
  output logic                            mem_req_o,
  input  logic                            mem_ack_i,
  output logic [ADDR_W-1:0]               mem_addr_o,
  output logic [PIXEL_W-1:0]              mem_data_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count_o,
  output logic                            overflow_o,
  output logic                            idle_o
);

  typedef enum logic {ST_IDLE, ST_REQ} state_t;

  state_t         state;
  logic           in_valid;
  logic           is_dup;
  logic           filt_valid;
  logic [X_W-1:0] last_x;
  logic [Y_W-1:0] last_y;
  logic           s1_valid;
  pixel_t         s1_pix;
  pixel_t         head;
  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_pop;

  assign in_valid = (X_i < X_LIMIT) && (Y_i < Y_LIMIT);
  assign is_dup   = filt_valid && (X_i == last_x) && (Y_i == last_y);

  // The head leaves the FIFO when the output register is free or being acknowledged.
  assign fifo_pop = !fifo_empty && ((state == ST_IDLE) || mem_ack_i);

  assign idle_o = !s1_valid && fifo_empty && (state == ST_IDLE);

  // Duplicate filter and stage 1: register address and packed colour of accepted samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_valid <= 1'b0;
      last_x     <= '0;
      last_y     <= '0;
      s1_valid   <= 1'b0;
      s1_pix     <= '0;
    end else begin
      filt_valid <= in_valid;
      if (in_valid) begin
        last_x <= X_i;
        last_y <= Y_i;
      end
      s1_valid    <= in_valid && !is_dup;
      s1_pix.addr <= linear_addr(X_i, Y_i);
      s1_pix.data <= {r_i, g_i, b_i};
    end
  end

  gpu_pixel_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W ($bits(pixel_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s1_valid),
    .wdata (s1_pix),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count_o)
  );

  // Sticky drop flag: stage-1 entry lost because the FIFO was full with no same-edge pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_o <= 1'b0;
    end else if (s1_valid && fifo_full && !fifo_pop) begin
      overflow_o <= 1'b1;
    end
  end

  // Output FSM: hold address/data while requesting, reload from the FIFO on acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state      <= ST_REQ;
            mem_req_o  <= 1'b1;
            mem_addr_o <= head.addr;
            mem_data_o <= head.data;
          end
        end
        ST_REQ: begin
          if (mem_ack_i) begin
            if (!fifo_empty) begin
              mem_addr_o <= head.addr;
              mem_data_o <= head.data;
            end else begin
              state     <= ST_IDLE;
              mem_req_o <= 1'b0;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_pixel_writer.sv
// Self-checking bench for gpu_pixel_writer: directed scenarios plus a random
// phase, all compared against a queue-based transaction model of the writer.

module tb_gpu_pixel_writer;

  localparam int W     = 640;
  localparam int H     = 480;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  X_i;
  logic [8:0]  Y_i;
  logic [7:0]  r_i, g_i, b_i;
  logic        mem_ack_i;
  logic        mem_req_o;
  logic [18:0] mem_addr_o;
  logic [23:0] mem_data_o;
  logic [3:0]  fifo_count_o;
  logic        overflow_o;
  logic        idle_o;

  always #5 clk = ~clk;

  gpu_pixel_writer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .X_i          (X_i),
    .Y_i          (Y_i),
    .r_i          (r_i),
    .g_i          (g_i),
    .b_i          (b_i),
    .mem_req_o    (mem_req_o),
    .mem_ack_i    (mem_ack_i),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .fifo_count_o (fifo_count_o),
    .overflow_o   (overflow_o),
    .idle_o       (idle_o)
  );

  typedef struct {
    int addr;
    int data;
  } pix_t;

  int total = 0;
  int bad   = 0;

  // Reference model: a pending pixel, a queue of buffered pixels, the pixel on the bus.
  bit   m_s1_v;
  pix_t m_s1;
  pix_t m_q[$];
  bit   m_out_v;
  pix_t m_out;
  bit   m_ovf;
  bit   m_fv;
  int   m_lx, m_ly;

  // Observations.
  int   wlog[$];
  int   dlog[$];
  int   peak;
  bit   any_req;
  bit   all_idle;
  bit   h_req, h_ack;
  int   h_addr, h_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1_v  = 0;
    m_q.delete();
    m_out_v = 0;
    m_ovf   = 0;
    m_fv    = 0;
    h_req   = 0;
  endtask

  // One clock edge of the writer as seen from its contract.
  task automatic model_edge(input int x, input int y, input int r, input int g,
                            input int b, input bit ack);
    int  sz;
    bit  pop;
    sz  = m_q.size();
    pop = (sz > 0) && (!m_out_v || ack);
    if (pop) begin
      m_out   = m_q.pop_front();
      m_out_v = 1;
    end else if (ack) begin
      m_out_v = 0;
    end
    if (m_s1_v) begin
      if (sz < DEPTH || pop) m_q.push_back(m_s1);
      else                   m_ovf = 1;
    end
    if (x < W && y < H) begin
      m_s1_v    = !(m_fv && x == m_lx && y == m_ly);
      m_s1.addr = y * W + x;
      m_s1.data = (r << 16) | (g << 8) | b;
      m_fv      = 1;
      m_lx      = x;
      m_ly      = y;
    end else begin
      m_s1_v = 0;
      m_fv   = 0;
    end
  endtask

  // Drive one cycle of inputs (entered at posedge+1), check, then advance one edge.
  task automatic cyc(input int x, input int y, input int r, input int g,
                     input int b, input bit ack);
    X_i = 10'(x); Y_i = 9'(y);
    r_i = 8'(r); g_i = 8'(g); b_i = 8'(b);
    mem_ack_i = ack;
    #1;
    check("req", mem_req_o, m_out_v);
    if (m_out_v) begin
      check("addr", mem_addr_o, m_out.addr);
      check("data", mem_data_o, m_out.data);
    end
    check("count", fifo_count_o, m_q.size());
    check("overflow", overflow_o, m_ovf);
    check("idle", idle_o, !m_s1_v && m_q.size() == 0 && !m_out_v);
    if (h_req && !h_ack) begin
      check("hold_req", mem_req_o, 1);
      check("hold_addr", mem_addr_o, h_addr);
      check("hold_data", mem_data_o, h_data);
    end
    h_req  = mem_req_o;
    h_ack  = mem_ack_i;
    h_addr = mem_addr_o;
    h_data = mem_data_o;
    if (mem_req_o && mem_ack_i) begin
      wlog.push_back(mem_addr_o);
      dlog.push_back(mem_data_o);
    end
    if (int'(fifo_count_o) > peak) peak = fifo_count_o;
    if (mem_req_o) any_req = 1;
    if (!idle_o) all_idle = 0;
    @(posedge clk);
    model_edge(x, y, r, g, b, ack);
    #1;
  endtask

  task automatic blank(input int n, input bit ack);
    for (int i = 0; i < n; i++) cyc(W, H, 0, 0, 0, ack);
  endtask

  task automatic clear_obs();
    wlog.delete();
    dlog.delete();
    peak     = 0;
    any_req  = 0;
    all_idle = 1;
  endtask

  // Reset asserted between edges; outputs must react without a clock.
  task automatic mid_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_req", mem_req_o, 0);
    check("rst_addr", mem_addr_o, 0);
    check("rst_data", mem_data_o, 0);
    check("rst_count", fifo_count_o, 0);
    check("rst_overflow", overflow_o, 0);
    check("rst_idle", idle_o, 1);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int px, py;
    rst = 1'b1;
    X_i = 10'(W); Y_i = 9'(H);
    r_i = '0; g_i = '0; b_i = '0;
    mem_ack_i = 1'b0;
    model_reset();
    clear_obs();
    @(posedge clk);
    #1;
    check("reset_req", mem_req_o, 0);
    check("reset_addr", mem_addr_o, 0);
    check("reset_data", mem_data_o, 0);
    check("reset_count", fifo_count_o, 0);
    check("reset_overflow", overflow_o, 0);
    check("reset_idle", idle_o, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single pixel with ack high.
    clear_obs();
    cyc(10, 2, 1, 2, 3, 1);
    blank(6, 1);
    check("single_writes", wlog.size(), 1);
    if (wlog.size() >= 1) begin
      check("single_addr", wlog[0], 1290);
      check("single_data", dlog[0], 32'h010203);
    end
    check("single_idle", idle_o, 1);

    // Sentinel and out-of-range coordinates only.
    clear_obs();
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) cyc(640, 480, 9, 9, 9, 1);
      else            cyc(700, 5, 9, 9, 9, 1);
    end
    check("invalid_any_req", any_req, 0);
    check("invalid_all_idle", all_idle, 1);
    check("invalid_writes", wlog.size(), 0);

    // Duplicate filter.
    clear_obs();
    for (int i = 0; i < 4; i++) cyc(5, 7, 4, 5, 6, 1);
    for (int i = 0; i < 3; i++) cyc(6, 7, 4, 5, 6, 1);
    blank(6, 1);
    check("dup_writes", wlog.size(), 2);
    if (wlog.size() >= 2) begin
      check("dup_addr0", wlog[0], 4485);
      check("dup_addr1", wlog[1], 4486);
    end

    // Fill beyond capacity with ack low, then drain.
    clear_obs();
    for (int i = 0; i < 12; i++) cyc(i, 0, i, 0, 0, 0);
    blank(3, 0);
    check("ovf_peak", peak, 8);
    check("ovf_flag", overflow_o, 1);
    blank(12, 1);
    check("ovf_writes", wlog.size(), 9);
    for (int i = 0; i < 9 && i < wlog.size(); i++) check("ovf_order", wlog[i], i);

    // Ack every third cycle.
    clear_obs();
    for (int c = 0; c < 30; c++) begin
      if (c < 5) cyc(100 + c, 50, c + 1, 2 * c, 255 - c, (c % 3) == 2);
      else       cyc(W, H, 0, 0, 0, (c % 3) == 2);
    end
    check("slow_writes", wlog.size(), 5);
    for (int i = 0; i < 5 && i < wlog.size(); i++) begin
      check("slow_addr", wlog[i], 32100 + i);
      check("slow_data", dlog[i], ((i + 1) << 16) | ((2 * i) << 8) | (255 - i));
    end

    // Reset with four pixels queued behind an active request.
    clear_obs();
    for (int i = 0; i < 5; i++) cyc(200 + i, 10, 7, 7, 7, 0);
    blank(2, 0);
    check("pre_rst_count", fifo_count_o, 4);
    check("pre_rst_req", mem_req_o, 1);
    mid_reset();
    clear_obs();
    blank(10, 1);
    check("post_rst_writes", wlog.size(), 0);
    check("post_rst_idle", idle_o, 1);

    // Random traffic against the model.
    px = 0; py = 0;
    for (int c = 0; c < 600; c++) begin
      int  sel;
      bit  ack;
      sel = $urandom_range(0, 5);
      if (sel == 0) begin
        px = $urandom_range(0, 1) ? W : 700; py = $urandom_range(0, 1) ? H : 3;
      end else if (sel >= 3) begin
        px = $urandom_range(0, W - 1); py = $urandom_range(0, H - 1);
      end else if (px >= W || py >= H) begin
        px = $urandom_range(0, 15); py = $urandom_range(0, 15);
      end
      ack = (c % 200 < 60) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
      cyc(px, py, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), ack);
      if (c == 300) mid_reset();
    end
    blank(20, 1);
    check("final_idle", idle_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
